// File: rtl/adjust_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adjust_pkg
// Brief    : Shared types and constants for the user-adjustment controller.
// Revision : 1.0 - initial release
// ============================================================================
package adjust_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    localparam int TGT_CONTRAST = 0;
    localparam int TGT_BRIGHT   = 1;
    localparam int TGT_SAT      = 2;
    localparam int TGT_TINT     = 3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Two-flop synchroniser, stability counter and press strobe.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import adjust_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_db,
    output logic o_press
);

    localparam int                 c_cnt_w    = cnt_width(DEBOUNCE_CYC);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYC - 1);

    logic [1:0]         r_sync;
    logic [1:0]         r_vld;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_db;
    logic               r_press;
    logic               r_armed;

    // A button held through reset must be seen low once before it may press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_press <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_vld   <= {r_vld[0], 1'b1};
            r_press <= 1'b0;
            if (r_vld[1] && !r_sync[1]) begin
                r_armed <= 1'b1;
            end
            if (r_sync[1] != r_db) begin
                if (r_cnt == c_cnt_last) begin
                    r_db    <= r_sync[1];
                    r_cnt   <= '0;
                    r_press <= r_sync[1] & r_armed;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_db    = r_db;
    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adjust_ctrl
// Brief    : Debounced up/down/select buttons steering frame-aligned inc/dec
//            pulses to one effect block. ADJUST_AUTO_REPEAT_EN adds auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module adjust_ctrl
    import adjust_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int NUM_TARGETS  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           btn_up,
    input  logic                           btn_dn,
    input  logic                           btn_sel,
    input  logic                           frame_start,
    output logic [NUM_TARGETS-1:0]         inc,
    output logic [NUM_TARGETS-1:0]         dec,
    output logic [$clog2(NUM_TARGETS)-1:0] sel,
    output logic                           pending
);

    localparam int                     c_sel_w    = $clog2(NUM_TARGETS);
    localparam logic [c_sel_w-1:0]     c_sel_last = c_sel_w'(NUM_TARGETS - 1);
    localparam logic [NUM_TARGETS-1:0] c_one      = NUM_TARGETS'(1);

    logic [2:0] w_raw;
    logic [2:0] w_db;
    logic [2:0] w_press;
    logic [1:0] w_req;
    logic       w_both;
    logic       w_unused_db_sel;

    assign w_raw           = {btn_sel, btn_dn, btn_up};
    assign w_both          = w_db[0] & w_db[1];
    assign w_unused_db_sel = w_db[2];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_deb (
                .clk     (clk),
                .rst     (rst),
                .i_btn   (w_raw[gi]),
                .o_db    (w_db[gi]),
                .o_press (w_press[gi])
            );
        end
    endgenerate

`ifdef ADJUST_AUTO_REPEAT_EN
    localparam int c_rpt_w = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [c_rpt_w-1:0] c_dly_last  = c_rpt_w'(REPEAT_DELAY - 1);
    localparam logic [c_rpt_w-1:0] c_rate_last = c_rpt_w'(REPEAT_RATE - 1);

    generate
        for (genvar gd = 0; gd < 2; gd++) begin : g_rpt
            rpt_state_t         r_state;
            logic [c_rpt_w-1:0] r_cnt;

            assign w_req[gd] = !w_both &&
                               ((r_state == RPT_IDLE   && w_press[gd]) ||
                                (r_state == RPT_DELAY  && r_cnt == c_dly_last  && w_db[gd]) ||
                                (r_state == RPT_REPEAT && r_cnt == c_rate_last && w_db[gd]));

            // Both directions held, or this one released, parks the FSM.
            always_ff @(posedge clk) begin
                if (rst || w_both || !w_db[gd]) begin
                    r_state <= RPT_IDLE;
                    r_cnt   <= '0;
                end else begin
                    case (r_state)
                        RPT_IDLE: begin
                            if (w_press[gd]) begin
                                r_state <= RPT_DELAY;
                                r_cnt   <= '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (r_cnt == c_dly_last) begin
                                r_state <= RPT_REPEAT;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        RPT_REPEAT: begin
                            if (r_cnt == c_rate_last) begin
                                r_cnt <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        default: begin
                            r_state <= RPT_IDLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    endgenerate
`else
    localparam int c_unused_rpt = REPEAT_DELAY + REPEAT_RATE;

    assign w_req = w_press[1:0] & {2{~w_both}};
`endif

    logic                   r_pend_inc;
    logic                   r_pend_dec;
    logic                   w_pend_inc_nxt;
    logic                   w_pend_dec_nxt;
    logic                   w_issue;
    logic [c_sel_w-1:0]     r_sel;
    logic [NUM_TARGETS-1:0] r_inc;
    logic [NUM_TARGETS-1:0] r_dec;
    logic [NUM_TARGETS-1:0] w_onehot;

    assign w_issue  = frame_start & (r_pend_inc | r_pend_dec);
    assign w_onehot = c_one << r_sel;

    // Issue frees the latch first so a same-cycle request waits a frame.
    always_comb begin
        w_pend_inc_nxt = r_pend_inc;
        w_pend_dec_nxt = r_pend_dec;
        if (w_issue) begin
            w_pend_inc_nxt = 1'b0;
            w_pend_dec_nxt = 1'b0;
        end
        if (w_req[0]) begin
            if (w_pend_dec_nxt) begin
                w_pend_dec_nxt = 1'b0;
            end else begin
                w_pend_inc_nxt = 1'b1;
            end
        end
        if (w_req[1]) begin
            if (w_pend_inc_nxt) begin
                w_pend_inc_nxt = 1'b0;
            end else begin
                w_pend_dec_nxt = 1'b1;
            end
        end
        if (w_press[2]) begin
            w_pend_inc_nxt = 1'b0;
            w_pend_dec_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_inc <= 1'b0;
            r_pend_dec <= 1'b0;
            r_sel      <= '0;
            r_inc      <= '0;
            r_dec      <= '0;
        end else begin
            r_pend_inc <= w_pend_inc_nxt;
            r_pend_dec <= w_pend_dec_nxt;
            r_inc      <= (w_issue && r_pend_inc) ? w_onehot : '0;
            r_dec      <= (w_issue && r_pend_dec) ? w_onehot : '0;
            if (w_press[2]) begin
                r_sel <= (r_sel == c_sel_last) ? '0 : r_sel + 1'b1;
            end
        end
    end

    assign inc     = r_inc;
    assign dec     = r_dec;
    assign sel     = r_sel;
    assign pending = r_pend_inc | r_pend_dec;

endmodule
`default_nettype wire

// File: tb/tb_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adjust_ctrl
// Brief    : Self-checking bench for adjust_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adjust_ctrl;

    localparam int         c_deb   = 4;
    localparam int         c_rdly  = 20;
    localparam int         c_rrate = 8;
    localparam int         c_ntgt  = 4;
    localparam logic [3:0] c_one   = 4'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_dn = 1'b0;
    logic        btn_sel = 1'b0;
    logic        frame_start = 1'b0;
    logic [3:0]  inc;
    logic [3:0]  dec;
    logic [1:0]  sel;
    logic        pending;

    always #5 clk = ~clk;

    adjust_ctrl #(
        .DEBOUNCE_CYC (c_deb),
        .REPEAT_DELAY (c_rdly),
        .REPEAT_RATE  (c_rrate),
        .NUM_TARGETS  (c_ntgt)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btn_up),
        .btn_dn      (btn_dn),
        .btn_sel     (btn_sel),
        .frame_start (frame_start),
        .inc         (inc),
        .dec         (dec),
        .sel         (sel),
        .pending     (pending)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_pulse = 0;
    int gcyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw history per button, elapsed-time repeat, signed pending step.
    bit h [3][0:16383];
    int k;
    bit m_db [3];
    bit m_press [3];
    bit m_seen [3];
    bit m_active [2];
    int m_tp [2];
    int m_pdir, m_sel, m_pulse, m_psel;

    function automatic bit hs(input int bt, input int j);
        return (j >= 1) ? h[bt][j] : 1'b0;
    endfunction

    task automatic model_edge(input bit r, input bit fs, input bit b [3]);
        bit req [2];
        bit both;
        bit flip;
        if (r) begin
            k = 0; m_pdir = 0; m_sel = 0; m_pulse = 0; m_psel = 0;
            for (int i = 0; i < 3; i++) begin m_db[i] = 0; m_press[i] = 0; m_seen[i] = 0; end
            for (int i = 0; i < 2; i++) begin m_active[i] = 0; m_tp[i] = 0; end
            return;
        end
        k++;
        both = m_db[0] & m_db[1];
        for (int d = 0; d < 2; d++) begin
            req[d] = 0;
`ifdef ADJUST_AUTO_REPEAT_EN
            if (both || !m_db[d]) begin
                m_active[d] = 0;
            end else if (m_press[d]) begin
                req[d] = 1; m_active[d] = 1; m_tp[d] = k;
            end else if (m_active[d]) begin
                int e;
                e = k - m_tp[d];
                req[d] = (e >= c_rdly) && ((e - c_rdly) % c_rrate == 0);
            end
`else
            req[d] = m_press[d] && !both;
`endif
        end
        m_pulse = 0;
        if (fs && m_pdir != 0) begin
            m_pulse = m_pdir; m_psel = m_sel; m_pdir = 0;
        end
        if (req[0]) m_pdir = (m_pdir + 1 > 1) ? 1 : m_pdir + 1;
        if (req[1]) m_pdir = (m_pdir - 1 < -1) ? -1 : m_pdir - 1;
        if (m_press[2]) begin
            m_pdir = 0; m_sel = (m_sel + 1) % c_ntgt;
        end
        for (int bt = 0; bt < 3; bt++) begin
            h[bt][k] = b[bt];
            if (k - 3 >= 1 && h[bt][k-3] == 1'b0) m_seen[bt] = 1;
            flip = 1;
            for (int i = 0; i < c_deb; i++) if (hs(bt, k - 2 - i) == m_db[bt]) flip = 0;
            m_press[bt] = flip && !m_db[bt] && m_seen[bt];
            if (flip) m_db[bt] = ~m_db[bt];
        end
    endtask

    task automatic cyc();
        bit b [3];
        logic [3:0] ei, ed;
        b[0] = btn_up; b[1] = btn_dn; b[2] = btn_sel;
        @(posedge clk);
        model_edge(rst, frame_start, b);
        #1;
        ei = (m_pulse == 1)  ? (c_one << m_psel) : 4'd0;
        ed = (m_pulse == -1) ? (c_one << m_psel) : 4'd0;
        chk("inc", inc, ei);
        chk("dec", dec, ed);
        chk("sel", sel, m_sel);
        chk("pending", pending, m_pdir != 0);
        chk("onehot", $countones(inc | dec) <= 1, 1);
        if ((inc | dec) != 0) n_pulse++;
        gcyc++;
    endtask

    task automatic run(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            frame_start = (per != 0) && (gcyc % per == 0);
            cyc();
        end
        frame_start = 1'b0;
    endtask

    task automatic set_btn(input int b, input bit v);
        case (b)
            0:       btn_up  = v;
            1:       btn_dn  = v;
            default: btn_sel = v;
        endcase
    endtask

    task automatic tap(input int b);
        set_btn(b, 1'b1);
        run(6, 0);
        set_btn(b, 1'b0);
        run(8, 0);
    endtask

    initial begin
        int cd [3];
        int exp_rpt;

        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_inc", inc, 0);
        chk("rst_sel", sel, 0);
        chk("rst_pend", pending, 0);
        rst = 1'b0;
        run(4, 0);

        // Bounce rejection then a clean press.
        for (int i = 0; i < 20; i++) begin
            btn_up = ((i / 2) % 2) != 0;
            cyc();
        end
        btn_up = 1'b0;
        run(8, 0);
        chk("bounce_pend", pending, 0);
        btn_up = 1'b1;
        run(6, 0);
        btn_up = 1'b0;
        cyc();
        chk("press_pend", pending, 1);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        chk("press_inc", inc, 4'b0001);
        cyc();
        chk("press_inc_off", inc, 0);
        run(10, 0);

        // Auto-repeat.
        n_pulse = 0;
        btn_up = 1'b1;
        run(60, 4);
        btn_up = 1'b0;
        run(16, 4);
`ifdef ADJUST_AUTO_REPEAT_EN
        exp_rpt = 6;
`else
        exp_rpt = 1;
`endif
        chk("repeat_pulses", n_pulse, exp_rpt);

        // Coalesce and cancel.
        n_pulse = 0;
        tap(0);
        tap(0);
        chk("coal_pend", pending, 1);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        run(4, 0);
        chk("coal_pulses", n_pulse, 1);
        n_pulse = 0;
        tap(0);
        tap(1);
        chk("cancel_pend", pending, 0);
        run(8, 4);
        chk("cancel_pulses", n_pulse, 0);

        // Select wrap.
        for (int i = 0; i < 5; i++) begin
            tap(2);
            chk("sel_wrap", sel, (i + 1) % c_ntgt);
        end
        tap(0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        chk("sel_inc", inc, 4'b0010);
        run(4, 0);

        // Select press clears a pending step.
        tap(0);
        chk("selclr_pend1", pending, 1);
        tap(2);
        chk("selclr_pend0", pending, 0);
        n_pulse = 0;
        run(8, 4);
        chk("selclr_pulses", n_pulse, 0);

        // Reset while holding up with a step pending.
        btn_up = 1'b1;
        run(40, 0);
        chk("rmh_pend_before", pending, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rmh_pend", pending, 0);
        chk("rmh_inc", inc, 0);
        chk("rmh_sel", sel, 0);
        n_pulse = 0;
        run(60, 4);
        chk("rmh_held_pulses", n_pulse, 0);
        btn_up = 1'b0;
        run(10, 4);
        tap(0);
        run(8, 4);
        chk("rmh_repress", n_pulse, 1);

        // Randomized soak.
        for (int i = 0; i < 3; i++) cd[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 3; b++) begin
                if (cd[b] == 0) begin
                    set_btn(b, $urandom_range(0, 2) == 0);
                    cd[b] = $urandom_range(1, 30);
                end else begin
                    cd[b]--;
                end
            end
            frame_start = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 699) == 0);
            cyc();
        end
        rst = 1'b0;
        frame_start = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
